// File: rtl/imm_enc_pkg.sv
// Shared opcode constants, instruction-format enum and opcode classifier for the
// RV32I immediate encoder.
package imm_enc_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  function automatic fmt_e opcode_to_fmt(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_R:             f = FMT_R;
      OP_I, OP_LOAD:    f = FMT_I;
      OP_S:             f = FMT_S;
      OP_B:             f = FMT_B;
      OP_LUI, OP_AUIPC: f = FMT_U;
      OP_JAL:           f = FMT_J;
      default:          f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_field_packer.sv
// Combinational packer: scatters the immediate and register fields into an RV32I word.
// Range checking of the immediate is compiled in only when IMM_RANGE_CHECK_EN is defined.
module imm_field_packer
  import imm_enc_pkg::*;
(
  input  fmt_e        i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_instr,
  output logic        o_range_err
);

  always_comb begin
    o_instr = {25'b0, i_opcode};
    case (i_fmt)
      FMT_R: o_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      FMT_I: o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
      FMT_S: o_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
      FMT_B: o_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                        i_imm[4:1], i_imm[11], i_opcode};
      FMT_U: o_instr = {i_imm[31:12], i_rd, i_opcode};
      FMT_J: o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
      default: o_instr = {25'b0, i_opcode};
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // A value fits a signed N-bit field when every bit above N-1 equals bit N-1.
  logic w_fit12, w_fit13, w_fit21;
  assign w_fit12 = (i_imm[31:11] == {21{i_imm[11]}});
  assign w_fit13 = (i_imm[31:12] == {20{i_imm[12]}});
  assign w_fit21 = (i_imm[31:20] == {12{i_imm[20]}});

  always_comb begin
    o_range_err = 1'b0;
    case (i_fmt)
      FMT_I, FMT_S: o_range_err = !w_fit12;
      FMT_B:        o_range_err = !w_fit13 || i_imm[0];
      FMT_J:        o_range_err = !w_fit21 || i_imm[0];
      FMT_U:        o_range_err = (i_imm[11:0] != 12'd0);
      default:      o_range_err = 1'b0;
    endcase
  end
`else
  assign o_range_err = 1'b0;
`endif

endmodule

// File: rtl/imm_instr_encoder.sv
// RV32I instruction encoder: valid/ready input, one registered output stage, handoff counter.
// Optional immediate range checking via IMM_RANGE_CHECK_EN (see imm_field_packer).
module imm_instr_encoder
  import imm_enc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count
);

  fmt_e             w_fmt;
  logic [31:0]      w_instr;
  logic             w_range_err;
  logic             w_err;
  logic             w_accept;
  logic             w_handoff;

  logic             r_out_valid;
  logic [31:0]      r_out_instr;
  logic             r_out_err;
  logic [CNT_W-1:0] r_cnt;

  assign w_fmt = opcode_to_fmt(in_opcode);

  imm_field_packer u_packer (
    .i_fmt       (w_fmt),
    .i_opcode    (in_opcode),
    .i_rd        (in_rd),
    .i_rs1       (in_rs1),
    .i_rs2       (in_rs2),
    .i_funct3    (in_funct3),
    .i_funct7    (in_funct7),
    .i_imm       (in_imm),
    .o_instr     (w_instr),
    .o_range_err (w_range_err)
  );

  // Unknown opcodes always flag, independent of the range-check build option.
  assign w_err     = (w_fmt == FMT_BAD) || w_range_err;
  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_handoff = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_instr <= 32'd0;
      r_out_err   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_instr <= w_instr;
        r_out_err   <= w_err;
      end else if (w_handoff) begin
        r_out_valid <= 1'b0;
      end
      if (w_handoff) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_err   = r_out_err;
  assign enc_count = r_cnt;

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Directed bench for imm_instr_encoder; counter narrowed to 4 bits so wrap is reachable quickly.
module tb_imm_instr_encoder;

  localparam int unsigned CW = 4;
`ifdef IMM_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [31:0]   in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic          out_err;
  logic [CW-1:0] enc_count;

  int total = 0;
  int bad   = 0;
  logic [CW-1:0] exp_cnt;
  logic [31:0]   held;

  imm_instr_encoder #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .enc_count (enc_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] imm);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
  endtask

  // One request with out_ready=1: check latency, output, then handoff and idle.
  task automatic one(input string tag, input logic [6:0] op, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] imm,
                     input logic [31:0] exp_instr, input logic exp_err);
    @(negedge clk);
    req(op, rd, rs1, rs2, f3, f7, imm);
    #1 chk({tag, "_prevalid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_instr"}, out_instr, exp_instr);
    chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
    @(negedge clk);
    exp_cnt = exp_cnt + 1'b1;
    chk({tag, "_idle"}, 32'(out_valid), 32'd0);
    chk({tag, "_keep"}, out_instr, exp_instr);
    chk({tag, "_cnt"}, 32'(enc_count), 32'(exp_cnt));
  endtask

  // n back-to-back ADDI rd=i, imm=i with out_ready=1.
  task automatic stream(input int n);
    @(negedge clk);
    req(7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_instr", out_instr, (32'(i - 1) << 20) | (32'(i - 1) << 7) | 32'h13);
      if (i < n) req(7'b0010011, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
      else in_valid = 1'b0;
    end
    @(negedge clk);
    chk("stream_idle", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    exp_cnt = '0;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_cnt", 32'(enc_count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    one("addi", 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF10093, 1'b0);
    one("sw",   7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8,        32'h00512423, 1'b0);
    one("lui",  7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
    one("jal",  7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h001000EF, 1'b0);
    one("add",  7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,        32'h002081B3, 1'b0);
    one("bne",  7'b1100011, 5'd0, 5'd1, 5'd0, 3'd1, 7'd0, 32'hFFFFFFFC, 32'hFE009EE3, 1'b0);
    one("beq3", 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,        32'h00000163, RC);
    one("addi2048", 7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h80000013, RC);
    one("addi2047", 7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047, 32'h7FF00013, 1'b0);
    one("luibad", 7'b0110111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001, 32'h00001037, RC);
    one("unk",  7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0000007F, 1'b1);

    // Back-pressure: A is held while B waits at the input.
    out_ready = 1'b0;
    @(negedge clk);
    req(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    @(negedge clk);
    req(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    held = out_instr;
    chk("bp_a", held, 32'hFFF10093);
    for (int k = 0; k < 3; k++) begin
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_hold", out_instr, 32'hFFF10093);
      chk("bp_cnt", 32'(enc_count), 32'(exp_cnt));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    chk("bp_b_valid", 32'(out_valid), 32'd1);
    chk("bp_b_instr", out_instr, 32'h123452B7);
    chk("bp_cnt_rel", 32'(enc_count), 32'(exp_cnt));
    @(negedge clk);
    exp_cnt = exp_cnt + 1'b1;
    chk("bp_cnt_b", 32'(enc_count), 32'(exp_cnt));
    chk("bp_idle", 32'(out_valid), 32'd0);

    // Streaming from a cleared counter, then wrap through all-ones.
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    stream(8);
    chk("stream_cnt8", 32'(enc_count), 32'd8);
    stream(7);
    chk("stream_cnt15", 32'(enc_count), 32'd15);
    stream(1);
    chk("stream_wrap", 32'(enc_count), 32'd0);

    // Asynchronous reset while an erroring word is held.
    out_ready = 1'b0;
    @(negedge clk);
    req(7'h7F, 5'd3, 5'd3, 5'd3, 3'd7, 7'd1, 32'h1234);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_valid", 32'(out_valid), 32'd1);
    chk("mid_instr", out_instr, 32'h0000007F);
    chk("mid_err", 32'(out_err), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_err", 32'(out_err), 32'd0);
    chk("arst_cnt", 32'(enc_count), 32'd0);
    chk("arst_instr", out_instr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
